drink_dispenser: RTL
====================

// Module: drink_dispenser
// PURPOSE
//  Dispenser-side responder of the vending machine drink-output handshake.
//  - Accepts a dispense request on drink_contral and drives the motor for a fixed time.
//  - Confirms the drop via the chute sensor.
//  - Answers with an active-low drink_out_fin pulse.
//  - Tracks can stock and flags jams (no drop seen) as a latched fault.
// PARAMETERS
//  MOTOR_CYCLES   1000  clk cycles motor_on stays high per dispense
//  DROP_TIMEOUT   4000  clk cycles to wait for sensor after motor stops
//  FIN_CYCLES     4     clk cycles drink_out_fin held low on completion
//  STOCK_W        4     width of stock counter
//  STOCK_INIT     8     stock loaded by reset and by refill (must be < 2**STOCK_W)
// PORTS
//  clk            in   1        system clock, all logic on posedge
//  rst            in   1        synchronous, active-high reset
//  drink_contral  in   1        dispense request level from controller; rising edge = request
//  sensor_drop    in   1        chute drop sensor, asynchronous; 2-FF synchronised inside
//  refill         in   1        one-cycle pulse: reload stock to STOCK_INIT
//  motor_on       out  1        dispense motor drive
//  drink_out_fin  out  1        active-low completion strobe; idles high
//  empty          out  1        stock == 0
//  fault          out  1        latched jam indication
//  stock          out  STOCK_W  remaining cans
// BEHAVIOUR
//  Reset values: motor_on=0, drink_out_fin=1, fault=0, stock=STOCK_INIT, empty=0, state=IDLE.
//  Request detect: drink_contral registered once; req_edge = cur & ~prev; acted on only in IDLE.
//  Sensor: sensor_drop -> 2-FF sync -> rising-edge detect; 3-cycle input latency.
//  FSM:
//   IDLE:      req_edge & ~empty & ~fault -> RUN (motor_on=1 next cycle). Otherwise the edge is discarded.
//   RUN:       motor_on=1, counter runs MOTOR_CYCLES. Sensor edge in RUN sets drop_seen.
//              At count end: drop_seen -> DONE, else -> WAIT_DROP.
//   WAIT_DROP: motor_on=0. Sensor edge -> DONE. Counter reaching DROP_TIMEOUT -> FAULT.
//              Sensor edge on the same cycle as timeout -> DONE (sensor wins).
//   DONE:      drink_out_fin=0 for exactly FIN_CYCLES, stock decremented once on entry.
//              Then -> IDLE, drop_seen cleared.
//   FAULT:     motor_on=0, fault=1, drink_out_fin=1. Exit only via rst; no decrement.
//  Stock: decrement saturates at 0 (never wraps); empty combinational from stock.
//   refill accepted in any state except RUN. refill and DONE-entry decrement on the same cycle -> refill wins.
//   refill and req_edge on the same cycle in IDLE -> stock reloads and the request is also accepted.
//  drink_contral staying high starts no second dispense; it must drop and rise again.
//  rst mid-operation (any state) -> all outputs to reset values next cycle; motor stops immediately.
//  Request latency: req rising edge at cycle N -> motor_on=1 at N+2.
//   motor_on falls MOTOR_CYCLES cycles after it rises.
// STRUCTURE
//  Shared package vending_pkg:
//   - disp_state_t enum (IDLE, RUN, WAIT_DROP, DONE, FAULT)
//   - default constants DISP_MOTOR_CYCLES, DISP_DROP_TIMEOUT, DISP_FIN_CYCLES
//  One sub-module dispense_timer:
//   - load/enable down-counter with terminal-count flag
//   - sized $clog2(max(MOTOR_CYCLES, DROP_TIMEOUT)+1)
//   - reused across RUN, WAIT_DROP and DONE
//  Sync, edge detect and stock logic stay inline.
// TESTING
//  1 Normal:
//    - Input: req edge with sensor pulse at RUN cycle 500.
//    - Expect: motor_on high exactly 1000 cycles, drink_out_fin low 4 cycles, stock 8->7, fault=0.
//  2 Late drop:
//    - Input: sensor pulse 2000 cycles after motor off.
//    - Expect: DONE via WAIT_DROP, stock decremented, no fault.
//  3 Jam:
//    - Input: no sensor pulse.
//    - Expect: fault=1 after 1000+4000 cycles, drink_out_fin stays 1, stock unchanged.
//    - Follow-up: further req edges ignored until rst.
//  4 Empty:
//    - Input: 8 dispenses, then a 9th req.
//    - Expect: empty=1, motor_on stays 0.
//    - Follow-up: refill -> stock=8, empty=0; next req dispenses.
//  5 Held request / busy:
//    - Input: drink_contral held high 3000 cycles; extra edges during RUN.
//    - Expect: exactly one dispense.
//  6 Reset mid-RUN:
//    - Input: rst at RUN cycle 300.
//    - Expect: motor_on=0 next cycle, stock=8, drink_out_fin=1, state IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and default timing constants for the vending machine dispense path.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_DONE      = 3'd3,
        ST_FAULT     = 3'd4
    } disp_state_t;

    localparam int DISP_MOTOR_CYCLES = 1000;
    localparam int DISP_DROP_TIMEOUT = 4000;
    localparam int DISP_FIN_CYCLES   = 4;
    localparam int DISP_STOCK_W      = 4;
    localparam int DISP_STOCK_INIT   = 8;

    function automatic int disp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Load/enable down-counter shared by the motor, drop-wait and fin phases.
// Load wins over enable; tc_o is high while the count sits at zero.
module dispense_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/drink_dispenser.sv
// Dispenser-side responder: request edge -> motor run -> drop confirm -> active-low fin strobe.
// Request edge to motor_on is 2 cycles; requests arriving outside IDLE are dropped, no backpressure.
module drink_dispenser
    import vending_pkg::*;
#(
    parameter int MOTOR_CYCLES = DISP_MOTOR_CYCLES,
    parameter int DROP_TIMEOUT = DISP_DROP_TIMEOUT,
    parameter int FIN_CYCLES   = DISP_FIN_CYCLES,
    parameter int STOCK_W      = DISP_STOCK_W,
    parameter int STOCK_INIT   = DISP_STOCK_INIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               drink_contral,
    input  logic               sensor_drop,
    input  logic               refill,
    output logic               motor_on,
    output logic               drink_out_fin,
    output logic               empty,
    output logic               fault,
    output logic [STOCK_W-1:0] stock
);

    localparam int TW = $clog2(disp_max(MOTOR_CYCLES, DROP_TIMEOUT) + 1);
    localparam logic [TW-1:0] RUN_LD  = TW'(MOTOR_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LD = TW'(DROP_TIMEOUT - 1);
    localparam logic [TW-1:0] FIN_LD  = TW'(FIN_CYCLES - 1);

    disp_state_t        state_q, state_d;
    logic               ctl_q, ctl_prev_q;
    logic               sens_s1_q, sens_s2_q, sens_s3_q;
    logic               drop_seen_q, drop_seen_d;
    logic               dec_pend_q, dec_pend_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               tmr_load, tmr_en, tmr_tc;
    logic [TW-1:0]      tmr_val;
    logic               req_edge, sens_edge;

    assign req_edge  = ctl_q & ~ctl_prev_q;
    assign sens_edge = sens_s2_q & ~sens_s3_q;

    dispense_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        drop_seen_d = drop_seen_q;
        dec_pend_d  = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle refill makes an empty machine dispensable right away.
                if (req_edge && (!empty || refill)) begin
                    state_d     = ST_RUN;
                    tmr_load    = 1'b1;
                    tmr_val     = RUN_LD;
                    drop_seen_d = 1'b0;
                end
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                if (sens_edge) drop_seen_d = 1'b1;
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (drop_seen_q || sens_edge) begin
                        state_d    = ST_DONE;
                        tmr_val    = FIN_LD;
                        dec_pend_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DROP;
                        tmr_val = WAIT_LD;
                    end
                end
            end
            ST_WAIT_DROP: begin
                tmr_en = 1'b1;
                // Sensor is checked before timeout so a coincident drop still completes.
                if (sens_edge) begin
                    state_d    = ST_DONE;
                    tmr_load   = 1'b1;
                    tmr_val    = FIN_LD;
                    dec_pend_d = 1'b1;
                end else if (tmr_tc) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d     = ST_IDLE;
                    drop_seen_d = 1'b0;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stock_d = stock_q;
        if (refill && (state_q != ST_RUN)) begin
            stock_d = STOCK_W'(STOCK_INIT);
        end else if (dec_pend_q && (stock_q != '0)) begin
            stock_d = stock_q - STOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctl_q       <= 1'b0;
            ctl_prev_q  <= 1'b0;
            sens_s1_q   <= 1'b0;
            sens_s2_q   <= 1'b0;
            sens_s3_q   <= 1'b0;
            drop_seen_q <= 1'b0;
            dec_pend_q  <= 1'b0;
            stock_q     <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q     <= state_d;
            ctl_q       <= drink_contral;
            ctl_prev_q  <= ctl_q;
            sens_s1_q   <= sensor_drop;
            sens_s2_q   <= sens_s1_q;
            sens_s3_q   <= sens_s2_q;
            drop_seen_q <= drop_seen_d;
            dec_pend_q  <= dec_pend_d;
            stock_q     <= stock_d;
        end
    end

    assign motor_on      = (state_q == ST_RUN);
    assign drink_out_fin = (state_q != ST_DONE);
    assign fault         = (state_q == ST_FAULT);
    assign stock         = stock_q;
    assign empty         = (stock_q == '0);

endmodule
